mp_add_seq: RTL and testbench



---
 rtl/brentkung.sv | 50 +++++
 rtl/mp_add_seq.sv | 122 ++++++++++++
 tb/tb_mp_add_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/brentkung.sv
// 16-bit Brent-Kung parallel-prefix adder.
// Ports:
//   A, B  - 16-bit addends
//   Cin   - carry into bit 0
//   Sum   - A + B + Cin, modulo 2^16
//   Cout  - carry out of bit 15
module brentkung (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] Sum,
  output logic        Cout
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_gg;
  logic [15:0] w_pp;

  // After the sweeps, w_gg[i] is the carry out of bit i (group [i:0] including Cin).
  always_comb begin
    w_g     = A & B;
    w_p     = A ^ B;
    w_gg    = w_g;
    w_pp    = w_p;
    // Fold Cin into bit 0 so every prefix automatically includes it.
    w_gg[0] = w_g[0] | (w_p[0] & Cin);
    // Up-sweep: bit i where (i+1) is a multiple of 2^(l+1) absorbs the group 2^l below it.
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 16; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          w_gg[4'(i)] = w_gg[4'(i)] | (w_pp[4'(i)] & w_gg[4'(i - (1 << l))]);
          w_pp[4'(i)] = w_pp[4'(i)] & w_pp[4'(i - (1 << l))];
        end
      end
    end
    // Down-sweep: fill the remaining positions from the nearest completed prefix.
    for (int l = 2; l >= 0; l--) begin
      for (int i = 0; i < 16; i++) begin
        if ((i >= 3 * (1 << l) - 1) && (((i + 1 - 3 * (1 << l)) % (2 << l)) == 0)) begin
          w_gg[4'(i)] = w_gg[4'(i)] | (w_pp[4'(i)] & w_gg[4'(i - (1 << l))]);
        end
      end
    end
  end

  assign Sum  = w_p ^ {w_gg[14:0], Cin};
  assign Cout = w_gg[15];

endmodule

// File: rtl/mp_add_seq.sv
// Word-serial multi-precision adder/subtractor built around one 16-bit Brent-Kung adder.
// Operands are processed 16 bits per clock, least-significant word first, with the
// word carry registered between clocks.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid, in_ready  - operand handshake (A, B, Cin, Sub)
//   A, B                - W-bit operands, W = 16*NWORDS
//   Cin                 - carry into word 0 (ignored when Sub=1)
//   Sub                 - 0: A+B+Cin, 1: A-B
//   out_valid, out_ready- result handshake (Sum, Cout)
//   Sum                 - registered W-bit result
//   Cout                - registered top carry; not-borrow when Sub=1
module mp_add_seq #(
  parameter int unsigned NWORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [16*NWORDS-1:0]   A,
  input  logic [16*NWORDS-1:0]   B,
  input  logic                   Cin,
  input  logic                   Sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [16*NWORDS-1:0]   Sum,
  output logic                   Cout
);

  localparam int unsigned W  = 16 * NWORDS;
  localparam int unsigned IW = $clog2(NWORDS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_sub;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_sum;
  logic            r_cout;

  logic [IW+3:0]   w_base;
  logic [15:0]     w_a_word;
  logic [15:0]     w_b_word;
  logic [15:0]     w_sum_word;
  logic            w_cout_word;
  logic            w_last;

  assign w_base   = {r_idx, 4'b0000};
  assign w_a_word = r_a[w_base +: 16];
  // Subtraction is A + ~B + 1; the +1 comes from the carry preset at accept time.
  assign w_b_word = r_b[w_base +: 16] ^ {16{r_sub}};
  assign w_last   = (r_idx == IW'(NWORDS - 1));

  brentkung u_adder (
    .A    (w_a_word),
    .B    (w_b_word),
    .Cin  (r_carry),
    .Sum  (w_sum_word),
    .Cout (w_cout_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (in_valid)  w_state_d = StRun;
      StRun:   if (w_last)    w_state_d = StDone;
      StDone:  if (out_ready) w_state_d = StIdle;
      default:                w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= B;
            r_sub   <= Sub;
            r_carry <= Sub | Cin;
            r_idx   <= '0;
          end
        end
        StRun: begin
          r_sum[w_base +: 16] <= w_sum_word;
          r_carry             <= w_cout_word;
          r_idx               <= r_idx + 1'b1;
          if (w_last) begin
            r_cout <= w_cout_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign Sum       = r_sum;
  assign Cout      = r_cout;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq with NWORDS=4 (64-bit operands).
module tb_mp_add_seq;

  localparam int unsigned NWORDS = 4;
  localparam int unsigned W      = 16 * NWORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Sum;
  logic         Cout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mp_add_seq #(.NWORDS(NWORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sub       (Sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout)
  );

  // Called at a negedge with the DUT idle; returns cycles from accept edge to out_valid.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, output int lat);
    A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (Sum !== 64'h0) begin n_err++; $display("FAIL reset_sum: got %h want 0", Sum); end
    n_cmp++; if (Cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b want 0", Cout); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_basic();
    int lat;
    do_op(64'h0000_0000_52A0_8194, 64'h0000_0000_9A44_1314, 1'b1, 1'b0, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL add_latency: got %0d want 4", lat); end
    n_cmp++; if (Sum !== 64'h0000_0000_ECE4_94A9) begin n_err++; $display("FAIL add_sum: got %h want 00000000ece494a9", Sum); end
    n_cmp++; if (Cout !== 1'b0) begin n_err++; $display("FAIL add_cout: got %b want 0", Cout); end
    handshake();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_valid_drop: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL add_ready_back: got %b want 1", in_ready); end
  endtask

  task automatic test_carry();
    int lat;
    do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, lat);
    n_cmp++; if (Sum !== 64'h0000_0000_0001_0000) begin n_err++; $display("FAIL word_carry_sum: got %h want 0000000000010000", Sum); end
    n_cmp++; if (Cout !== 1'b0) begin n_err++; $display("FAIL word_carry_cout: got %b want 0", Cout); end
    handshake();
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, lat);
    n_cmp++; if (Sum !== 64'h0) begin n_err++; $display("FAIL ripple_sum: got %h want 0", Sum); end
    n_cmp++; if (Cout !== 1'b1) begin n_err++; $display("FAIL ripple_cout: got %b want 1", Cout); end
    handshake();
  endtask

  task automatic test_sub();
    int lat;
    do_op(64'd5, 64'd7, 1'b1, 1'b1, lat);
    n_cmp++; if (Sum !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL sub_neg_sum: got %h want fffffffffffffffe", Sum); end
    n_cmp++; if (Cout !== 1'b0) begin n_err++; $display("FAIL sub_neg_cout: got %b want 0", Cout); end
    handshake();
    do_op(64'd7, 64'd5, 1'b0, 1'b1, lat);
    n_cmp++; if (Sum !== 64'd2) begin n_err++; $display("FAIL sub_pos_sum: got %h want 2", Sum); end
    n_cmp++; if (Cout !== 1'b1) begin n_err++; $display("FAIL sub_pos_cout: got %b want 1", Cout); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL bp_latency: got %0d want 4", lat); end
    // Offer a new bundle while the result is stalled; it must not be taken.
    A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'h1; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", k, out_valid); end
      n_cmp++; if (Sum !== 64'h2345_6789_ABCD_F001) begin n_err++; $display("FAIL bp_sum[%0d]: got %h want 23456789abcdf001", k, Sum); end
      n_cmp++; if (Cout !== 1'b0) begin n_err++; $display("FAIL bp_cout[%0d]: got %b want 0", k, Cout); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    A = 64'h1111_1111_1111_1111; B = 64'h2222_2222_2222_2222; Cin = 1'b0; Sub = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);   // two words done, idx=2
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (Sum !== 64'h0) begin n_err++; $display("FAIL midrst_sum: got %h want 0", Sum); end
    n_cmp++; if (Cout !== 1'b0) begin n_err++; $display("FAIL midrst_cout: got %b want 0", Cout); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_no_pulse: got %b want 0", out_valid); end
    do_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, lat);
    n_cmp++; if (Sum !== 64'h2345_6789_ABCD_F001) begin n_err++; $display("FAIL midrst_after_sum: got %h want 23456789abcdf001", Sum); end
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL midrst_after_lat: got %0d want 4", lat); end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ba [3];
    logic [W-1:0] bb [3];
    logic         bc [3];
    logic         bs [3];
    logic [W-1:0] es [3];
    logic         ec [3];
    int           t  [3];
    int cyc, bi, ri;
    logic acc;
    ba[0] = 64'h0123_4567_89AB_CDEF; bb[0] = 64'hFEDC_BA98_7654_3210; bc[0] = 1'b1; bs[0] = 1'b0;
    es[0] = 64'h0;                   ec[0] = 1'b1;
    ba[1] = 64'h8000_0000_0000_0000; bb[1] = 64'h1;                   bc[1] = 1'b0; bs[1] = 1'b1;
    es[1] = 64'h7FFF_FFFF_FFFF_FFFF; ec[1] = 1'b1;
    ba[2] = 64'h0000_FFFF_0000_FFFF; bb[2] = 64'h0000_0001_0000_0001; bc[2] = 1'b0; bs[2] = 1'b0;
    es[2] = 64'h0001_0000_0001_0000; ec[2] = 1'b0;
    t[0] = 0; t[1] = 0; t[2] = 0;
    cyc = 0; bi = 0; ri = 0;
    out_ready = 1'b1;
    A = ba[0]; B = bb[0]; Cin = bc[0]; Sub = bs[0]; in_valid = 1'b1;
    while (ri < 3 && cyc < 60) begin
      acc = in_ready && in_valid;
      if (out_valid) begin
        n_cmp++; if (Sum !== es[ri]) begin n_err++; $display("FAIL b2b_sum[%0d]: got %h want %h", ri, Sum, es[ri]); end
        n_cmp++; if (Cout !== ec[ri]) begin n_err++; $display("FAIL b2b_cout[%0d]: got %b want %b", ri, Cout, ec[ri]); end
        t[ri] = cyc;
        ri++;
      end
      @(negedge clk);
      cyc++;
      // Advancing the bundle right after accept also changes A mid-RUN.
      if (acc) begin
        bi++;
        if (bi < 3) begin
          A = ba[bi]; B = bb[bi]; Cin = bc[bi]; Sub = bs[bi];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    n_cmp++; if (ri !== 3) begin n_err++; $display("FAIL b2b_count: got %0d results want 3", ri); end
    n_cmp++; if (t[1] - t[0] !== 6) begin n_err++; $display("FAIL b2b_spacing01: got %0d want 6", t[1] - t[0]); end
    n_cmp++; if (t[2] - t[1] !== 6) begin n_err++; $display("FAIL b2b_spacing12: got %0d want 6", t[2] - t[1]); end
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_carry();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
